// File: rtl/bp_iteration_scheduler.sv
// Iteration sequencer for a belief-propagation decoder: clears accumulators, then loops
// row update -> column sum -> syndrome check until the syndrome is zero, the limit is hit, or abort.
module bp_iteration_scheduler #(
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  output logic              clr,
  output logic              row_start,
  input  logic              row_done,
  output logic              col_start,
  input  logic              col_done,
  output logic              syn_start,
  input  logic              syn_done,
  input  logic              syn_zero,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLR      = 4'd1;
  localparam logic [3:0] S_ROW_GO   = 4'd2;
  localparam logic [3:0] S_ROW_WAIT = 4'd3;
  localparam logic [3:0] S_COL_GO   = 4'd4;
  localparam logic [3:0] S_COL_WAIT = 4'd5;
  localparam logic [3:0] S_SYN_GO   = 4'd6;
  localparam logic [3:0] S_SYN_WAIT = 4'd7;
  localparam logic [3:0] S_FINISH   = 4'd8;

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [ITER_W-1:0] limit;
  logic [ITER_W-1:0] iter_inc;
  logic              limit_hit;
  logic              in_decode;
  logic              syn_accept;

  // Abortable states are the contiguous encodings CLR..SYN_WAIT.
  assign in_decode  = (state >= S_CLR) && (state <= S_SYN_WAIT);
  assign iter_inc   = (&iter_count) ? iter_count : iter_count + 1'b1;
  assign limit_hit  = ({1'b0, iter_count} + 1'b1) >= {1'b0, limit};
  assign syn_accept = (state == S_SYN_WAIT) && syn_done && !abort;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_CLR;
      S_CLR:      state_next = S_ROW_GO;
      S_ROW_GO:   state_next = S_ROW_WAIT;
      S_ROW_WAIT: if (row_done) state_next = S_COL_GO;
      S_COL_GO:   state_next = S_COL_WAIT;
      S_COL_WAIT: if (col_done) state_next = S_SYN_GO;
      S_SYN_GO:   state_next = S_SYN_WAIT;
      S_SYN_WAIT: if (syn_done) state_next = (syn_zero || limit_hit) ? S_FINISH : S_ROW_GO;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (in_decode && abort) state_next = S_FINISH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      limit      <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        limit      <= (max_iter == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : max_iter;
        iter_count <= '0;
        converged  <= 1'b0;
      end else if (in_decode && abort) begin
        converged <= 1'b0;
      end else if (syn_accept) begin
        iter_count <= iter_inc;
        converged  <= syn_zero;
      end
    end
  end

  assign clr       = (state == S_CLR);
  assign row_start = (state == S_ROW_GO);
  assign col_start = (state == S_COL_GO);
  assign syn_start = (state == S_SYN_GO);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_bp_iteration_scheduler.sv
// Directed bench: sub-unit responder model with programmable latency, syndrome-zero
// position and abort injection; checks are immediate assertions against hand-derived values.
module tb_bp_iteration_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] max_iter = '0;
  logic       clr, row_start, col_start, syn_start, busy, done, converged;
  logic       row_done = 1'b0, col_done = 1'b0, syn_done = 1'b0, syn_zero = 1'b0;
  logic [5:0] iter_count;

  int checks = 0;
  int errors = 0;

  int lat = 1;
  int zero_at = 0;
  logic abort_arm = 1'b0;
  logic abort_force = 1'b0;
  logic stray_row = 1'b0;
  int row_t = 0, col_t = 0, syn_t = 0, syn_n = 0;
  int row_pulses = 0, col_pulses = 0, syn_pulses = 0;
  int r0, c0, s0, cyc;

  bp_iteration_scheduler #(.ITER_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .max_iter(max_iter),
    .clr(clr), .row_start(row_start), .row_done(row_done),
    .col_start(col_start), .col_done(col_done),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Sub-unit model: each unit answers `lat` cycles after its start pulse.
  always @(negedge clk) begin
    if (rst) begin
      row_t = 0; col_t = 0; syn_t = 0; syn_n = 0;
      row_done = 0; col_done = 0; syn_done = 0; syn_zero = 0; abort = 0;
    end else begin
      row_done = stray_row; col_done = 0; syn_done = 0; syn_zero = 0;
      if (clr) syn_n = 0;
      if (row_start) row_t = lat;
      else if (row_t > 0) begin row_t--; if (row_t == 0) row_done = 1; end
      if (col_start) col_t = lat;
      else if (col_t > 0) begin col_t--; if (col_t == 0) col_done = 1; end
      if (syn_start) syn_t = lat;
      else if (syn_t > 0) begin
        syn_t--;
        if (syn_t == 0) begin
          syn_done = 1; syn_n++; syn_zero = (syn_n == zero_at);
        end
      end
      abort = abort_force || (abort_arm && col_done && syn_n == 1);
      row_pulses += int'(row_start);
      col_pulses += int'(col_start);
      syn_pulses += int'(syn_start);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); n++;
      if (done) break;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task automatic start_decode(input logic [5:0] mi);
    @(negedge clk); start = 1; max_iter = mi;
    @(negedge clk); start = 0;
  endtask

  task automatic snap();
    r0 = row_pulses; c0 = col_pulses; s0 = syn_pulses;
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_clr", clr, 0);
    chk("rst_starts", {row_start, col_start, syn_start}, 0);
    chk("rst_done", done, 0);
    chk("rst_converged", converged, 0);
    chk("rst_iter", iter_count, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);

    // Minimum decode: 1 iteration, 1-cycle responders; start cycle through done cycle = 9
    lat = 1; zero_at = 0;
    start = 1; max_iter = 6'd1;
    @(negedge clk);
    chk("min_clr", clr, 1);
    chk("min_busy", busy, 1);
    start = 0; max_iter = 6'd0;
    wait_done("min", cyc);
    chk("min_latency", cyc + 2, 9);
    chk("min_iter", iter_count, 1);
    chk("min_conv", converged, 0);

    // Start in FINISH ignored, start in following IDLE accepted; max_iter=3, no convergence
    snap();
    start = 1; max_iter = 6'd3; lat = 2;
    @(negedge clk);
    chk("fin_start_ignored_busy", busy, 0);
    chk("fin_iter_hold", iter_count, 1);
    @(negedge clk);
    chk("idle_start_clr", clr, 1);
    chk("idle_start_iter_zero", iter_count, 0);
    start = 0; max_iter = 6'd0;
    wait_done("lim3", cyc);
    chk("lim3_rows", row_pulses - r0, 3);
    chk("lim3_cols", col_pulses - c0, 3);
    chk("lim3_syns", syn_pulses - s0, 3);
    chk("lim3_iter", iter_count, 3);
    chk("lim3_conv", converged, 0);
    @(negedge clk);
    chk("lim3_done_one_cycle", done, 0);
    chk("lim3_idle", busy, 0);

    // Converge at 2nd syndrome, limit 10
    lat = 1; zero_at = 2; snap();
    start_decode(6'd10);
    wait_done("conv2", cyc);
    chk("conv2_iter", iter_count, 2);
    chk("conv2_conv", converged, 1);
    chk("conv2_cols", col_pulses - c0, 2);
    @(negedge clk);
    chk("conv2_conv_hold", converged, 1);
    chk("conv2_iter_hold", iter_count, 2);

    // Zero syndrome and limit reached together: converged wins
    zero_at = 1;
    start_decode(6'd1);
    wait_done("prio", cyc);
    chk("prio_conv", converged, 1);
    chk("prio_iter", iter_count, 1);

    // max_iter = 0 behaves as a limit of 1
    zero_at = 0; snap();
    start_decode(6'd0);
    wait_done("zero_lim", cyc);
    chk("zero_lim_iter", iter_count, 1);
    chk("zero_lim_conv", converged, 0);
    chk("zero_lim_rows", row_pulses - r0, 1);

    // Abort in IDLE has no effect
    @(negedge clk); abort_force = 1;
    @(negedge clk); @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);
    abort_force = 0;
    @(negedge clk);

    // Abort in COL_WAIT of iteration 2 coinciding with col_done
    lat = 2; abort_arm = 1; snap();
    start_decode(6'd5);
    wait_done("abort", cyc);
    chk("abort_conv", converged, 0);
    chk("abort_iter", iter_count, 1);
    chk("abort_syns", syn_pulses - s0, 1);
    chk("abort_cols", col_pulses - c0, 2);
    abort_arm = 0;
    @(negedge clk);
    chk("abort_done_one_cycle", done, 0);

    // Asynchronous reset mid ROW_WAIT of iteration 2
    lat = 2;
    start_decode(6'd5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_start && iter_count == 6'd1) break;
    end
    chk("arst_reached_row_go", row_start, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_iter", iter_count, 0);
    chk("arst_outs", {clr, row_start, col_start, syn_start, done, converged}, 0);
    @(negedge clk); rst = 0;
    stray_row = 1;
    @(negedge clk); @(negedge clk);
    stray_row = 0;
    chk("stray_row_busy", busy, 0);
    chk("stray_row_col_start", col_start, 0);
    lat = 1; snap();
    start_decode(6'd2);
    wait_done("post_arst", cyc);
    chk("post_arst_iter", iter_count, 2);
    chk("post_arst_conv", converged, 0);
    chk("post_arst_rows", row_pulses - r0, 2);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
